// File: rtl/coffee_machine_pkg.sv
// Shared types and helpers for the coin-operated beverage controller.
// Optional feature macro used by the top: COFFEE_MACHINE_SUGAR_EN.
package coffee_machine_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WATER  = 3'd1,
    COFFEE = 3'd2,
    MILK   = 3'd3,
    CHOC   = 3'd4,
    SUGAR  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Ingredient mask bit positions: [0]=water [1]=coffee [2]=milk [3]=chocolate [4]=sugar
  typedef struct packed {
    logic [3:0] price;
    logic [4:0] mask;
  } recipe_t;

  localparam logic [3:0] COIN_100_VAL = 4'd1;
  localparam logic [3:0] COIN_500_VAL = 4'd5;
  localparam logic [3:0] CREDIT_MAX   = 4'd9;

  // Price and ingredient set per beverage code; invalid codes return price 0, empty mask.
  function automatic recipe_t recipe_lookup(input logic [2:0] kind);
    recipe_t r;
    case (kind)
      3'b001:  r = '{price: 4'd3, mask: 5'b10011};
      3'b010:  r = '{price: 4'd4, mask: 5'b10111};
      3'b011:  r = '{price: 4'd5, mask: 5'b11111};
      3'b100:  r = '{price: 4'd4, mask: 5'b11101};
      default: r = '{price: 4'd0, mask: 5'b00000};
    endcase
    return r;
  endfunction

  // First step after cur that is present in mask; DONE when none remain.
  // Later assignments win, so the lowest qualifying step is chosen.
  function automatic state_t next_step(input state_t cur, input logic [4:0] mask);
    state_t res;
    res = DONE;
    if (mask[4] && (cur < SUGAR))  res = SUGAR;
    if (mask[3] && (cur < CHOC))   res = CHOC;
    if (mask[2] && (cur < MILK))   res = MILK;
    if (mask[1] && (cur < COFFEE)) res = COFFEE;
    if (mask[0] && (cur < WATER))  res = WATER;
    return res;
  endfunction

endpackage

// File: rtl/coffee_machine_seven_seg_decoder.sv
// BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module seven_seg_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern.
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/coffee_machine.sv
// Coin-operated beverage vending controller: credit accumulation, recipe
// sequencing with STEP_CYCLES per ingredient, change computation, 7-seg display.
// Macro COFFEE_MACHINE_SUGAR_EN enables the sugar step; without it sugar is skipped.
module coffee_machine
  import coffee_machine_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [2:0] coffee_type,
  input  logic       confirm,
  output logic [6:0] total_coins_display,
  output logic [6:0] change_display,
  output logic       water,
  output logic       coffee,
  output logic       sugar,
  output logic       milk,
  output logic       chocolate,
  output logic       finished
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

`ifdef COFFEE_MACHINE_SUGAR_EN
  localparam logic [4:0] STEP_ENABLE = 5'b11111;
`else
  localparam logic [4:0] STEP_ENABLE = 5'b01111;
`endif

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     mask_q, mask_d;
  logic [3:0]     credit_q, credit_d;
  logic [3:0]     change_q, change_d;
  logic           c100_prev_q, c100_prev_d;
  logic           c500_prev_q, c500_prev_d;
  logic [4:0]     valves_q, valves_d;
  logic           finished_q, finished_d;
  logic [6:0]     tot_disp_q, tot_disp_d;
  logic [6:0]     chg_disp_q, chg_disp_d;

  logic           edge100_s, edge500_s;
  recipe_t        rec_s;
  logic [4:0]     eff_mask_s;
  logic           can_buy_s;
  logic [4:0]     credit_sum_s;
  logic [6:0]     tot_seg_s, chg_seg_s;

  assign edge100_s    = coin_100 & ~c100_prev_q;
  assign edge500_s    = coin_500 & ~c500_prev_q;
  assign rec_s        = recipe_lookup(coffee_type);
  assign eff_mask_s   = rec_s.mask & STEP_ENABLE;
  assign can_buy_s    = (rec_s.price != 4'd0) && (credit_q >= rec_s.price);
  assign credit_sum_s = {1'b0, credit_q}
                      + (edge100_s ? {1'b0, COIN_100_VAL} : 5'd0)
                      + (edge500_s ? {1'b0, COIN_500_VAL} : 5'd0);

  seven_seg_decoder u_total_seg (.digit(credit_q), .seg(tot_seg_s));
  seven_seg_decoder u_change_seg (.digit(change_q), .seg(chg_seg_s));

  // Next-state: credit/change bookkeeping, step sequencing, registered output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    credit_d    = credit_q;
    change_d    = change_q;
    c100_prev_d = coin_100;
    c500_prev_d = coin_500;
    valves_d    = 5'b00000;
    finished_d  = 1'b0;
    tot_disp_d  = tot_seg_s;
    chg_disp_d  = chg_seg_s;

    case (state_q)
      IDLE: begin
        if (confirm && can_buy_s) begin
          change_d = credit_q - rec_s.price;
          credit_d = 4'd0;
          mask_d   = eff_mask_s;
          cnt_d    = '0;
          state_d  = next_step(IDLE, eff_mask_s);
        end else if (edge100_s || edge500_s) begin
          credit_d = (credit_sum_s > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : credit_sum_s[3:0];
          change_d = 4'd0;
        end else begin
          credit_d = credit_q;
        end
      end
      WATER, COFFEE, MILK, CHOC, SUGAR: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = next_step(state_q, mask_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Valves and finished are registered alongside the state they belong to.
    case (state_d)
      WATER:   valves_d = 5'b00001;
      COFFEE:  valves_d = 5'b00010;
      MILK:    valves_d = 5'b00100;
      CHOC:    valves_d = 5'b01000;
      SUGAR:   valves_d = 5'b10000 & STEP_ENABLE;
      DONE:    finished_d = 1'b1;
      default: valves_d = 5'b00000;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= 5'b00000;
      credit_q    <= 4'd0;
      change_q    <= 4'd0;
      c100_prev_q <= 1'b0;
      c500_prev_q <= 1'b0;
      valves_q    <= 5'b00000;
      finished_q  <= 1'b0;
      tot_disp_q  <= 7'b1000000;
      chg_disp_q  <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      credit_q    <= credit_d;
      change_q    <= change_d;
      c100_prev_q <= c100_prev_d;
      c500_prev_q <= c500_prev_d;
      valves_q    <= valves_d;
      finished_q  <= finished_d;
      tot_disp_q  <= tot_disp_d;
      chg_disp_q  <= chg_disp_d;
    end
  end

  assign water               = valves_q[0];
  assign coffee              = valves_q[1];
  assign milk                = valves_q[2];
  assign chocolate           = valves_q[3];
  assign sugar               = valves_q[4];
  assign finished            = finished_q;
  assign total_coins_display = tot_disp_q;
  assign change_display      = chg_disp_q;

endmodule

// File: tb/tb_coffee_machine.sv
// Self-checking bench for coffee_machine with a behavioural vending model.
module tb_coffee_machine;

  localparam int S = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       coin_100 = 1'b0;
  logic       coin_500 = 1'b0;
  logic [2:0] coffee_type = 3'd0;
  logic       confirm = 1'b0;
  logic [6:0] total_coins_display, change_display;
  logic       water, coffee, sugar, milk, chocolate, finished;

  int checks = 0;
  int errors = 0;
  int credit_m = 0;
  int change_m = 0;
  bit sugar_en;
  logic [4:0] exp_steps[$];

  coffee_machine #(.STEP_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .coffee_type(coffee_type), .confirm(confirm),
    .total_coins_display(total_coins_display), .change_display(change_display),
    .water(water), .coffee(coffee), .sugar(sugar), .milk(milk),
    .chocolate(chocolate), .finished(finished)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Valve vector as seen by the bench: {water,coffee,milk,chocolate,sugar}
  localparam logic [4:0] V_W = 5'b10000, V_C = 5'b01000, V_M = 5'b00100,
                         V_H = 5'b00010, V_S = 5'b00001;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000; 1: return 7'b1111001; 2: return 7'b0100100;
      3: return 7'b0110000; 4: return 7'b0011001; 5: return 7'b0010010;
      6: return 7'b0000010; 7: return 7'b1111000; 8: return 7'b0000000;
      9: return 7'b0010000; default: return 7'b1111111;
    endcase
  endfunction

  function automatic int price_of(input int t);
    case (t)
      1: return 3; 2: return 4; 3: return 5; 4: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] valves_now();
    return {water, coffee, milk, chocolate, sugar};
  endfunction

  task automatic build_steps(input int t);
    exp_steps.delete();
    case (t)
      1: begin exp_steps.push_back(V_W); exp_steps.push_back(V_C); end
      2: begin exp_steps.push_back(V_W); exp_steps.push_back(V_C); exp_steps.push_back(V_M); end
      3: begin exp_steps.push_back(V_W); exp_steps.push_back(V_C); exp_steps.push_back(V_M);
               exp_steps.push_back(V_H); end
      4: begin exp_steps.push_back(V_W); exp_steps.push_back(V_M); exp_steps.push_back(V_H); end
      default: ;
    endcase
    if (sugar_en && price_of(t) != 0) exp_steps.push_back(V_S);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_displays(input string tag);
    checks++;
    if (total_coins_display !== seg_of(credit_m)) begin
      errors++;
      $display("FAIL %s credit_disp got %b want %b", tag, total_coins_display, seg_of(credit_m));
    end
    checks++;
    if (change_display !== seg_of(change_m)) begin
      errors++;
      $display("FAIL %s change_disp got %b want %b", tag, change_display, seg_of(change_m));
    end
  endtask

  task automatic pulse(input bit c1, input bit c5);
    coin_100 = c1;
    coin_500 = c5;
    tick();
    coin_100 = 1'b0;
    coin_500 = 1'b0;
    tick();
    tick();
    credit_m = credit_m + (c1 ? 1 : 0) + (c5 ? 5 : 0);
    if (credit_m > 9) credit_m = 9;
    change_m = 0;
  endtask

  task automatic run_dispense(input int t, input int coin_at, input string tag);
    int n, lat;
    logic [4:0] ev;
    logic ef;
    build_steps(t);
    n = exp_steps.size();
    lat = 1 + n * S;
    change_m = credit_m - price_of(t);
    credit_m = 0;
    coffee_type = 3'(t);
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    coffee_type = 3'($urandom_range(0, 7));
    for (int k = 1; k <= lat; k++) begin
      if (k == coin_at) begin
        coin_100 = 1'b1;
        coin_500 = 1'b1;
      end else begin
        coin_100 = 1'b0;
        coin_500 = 1'b0;
      end
      ev = (k < lat) ? exp_steps[(k - 1) / S] : 5'b00000;
      ef = (k == lat);
      checks++;
      if (valves_now() !== ev || finished !== ef) begin
        errors++;
        $display("FAIL %s cycle %0d valves/fin got %b/%b want %b/%b",
                 tag, k, valves_now(), finished, ev, ef);
      end
      if (k < lat) tick();
    end
    coin_100 = 1'b0;
    coin_500 = 1'b0;
    tick();
    checks++;
    if (valves_now() !== 5'b00000 || finished !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done got %b/%b want 00000/0", tag, valves_now(), finished);
    end
    tick();
    check_displays(tag);
  endtask

  task automatic run_reject(input int t, input string tag);
    coffee_type = 3'(t);
    confirm = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (valves_now() !== 5'b00000 || finished !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d valves/fin got %b/%b want 00000/0", tag, k, valves_now(), finished);
      end
    end
    confirm = 1'b0;
    tick();
    check_displays(tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    credit_m = 0;
    change_m = 0;
    checks++;
    if (valves_now() !== 5'b00000 || finished !== 1'b0) begin
      errors++;
      $display("FAIL reset valves/fin got %b/%b want 00000/0", valves_now(), finished);
    end
    checks++;
    if (total_coins_display !== 7'b1000000 || change_display !== 7'b1000000) begin
      errors++;
      $display("FAIL reset displays got %b/%b want 1000000/1000000", total_coins_display, change_display);
    end
    tick();
  endtask

  task automatic test_coins();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    checks++;
    if (total_coins_display !== 7'b1111000) begin
      errors++;
      $display("FAIL coins_seven got %b want 1111000", total_coins_display);
    end
    check_displays("coins");
  endtask

  task automatic test_mocha();
    run_dispense(3, 0, "mocha");
    checks++;
    if (change_display !== 7'b0100100 || total_coins_display !== 7'b1000000) begin
      errors++;
      $display("FAIL mocha_change got %b/%b want 0100100/1000000", change_display, total_coins_display);
    end
  endtask

  task automatic test_insufficient();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    run_reject(1, "insufficient");
  endtask

  task automatic test_saturate();
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    checks++;
    if (total_coins_display !== 7'b0010000) begin
      errors++;
      $display("FAIL saturate got %b want 0010000", total_coins_display);
    end
    check_displays("saturate");
  endtask

  task automatic test_invalid();
    run_reject(7, "invalid7");
    run_reject(0, "invalid0");
    run_reject(5, "invalid5");
    run_reject(6, "invalid6");
  endtask

  task automatic test_coin_mid();
    run_dispense(2, 6, "coin_mid");
    pulse(1'b1, 1'b1);
    check_displays("both_coins");
    run_dispense(4, 1 + 4 * S, "coin_done_edge");
  endtask

  task automatic test_reset_mid();
    pulse(1'b0, 1'b1);
    coffee_type = 3'd3;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    for (int k = 0; k < S + 1; k++) tick();
    checks++;
    if (valves_now() !== V_C) begin
      errors++;
      $display("FAIL reset_mid precheck got %b want %b", valves_now(), V_C);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    credit_m = 0;
    change_m = 0;
    checks++;
    if (valves_now() !== 5'b00000 || finished !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid valves/fin got %b/%b want 00000/0", valves_now(), finished);
    end
    check_displays("reset_mid");
    for (int k = 0; k < 3 * S; k++) begin
      tick();
      checks++;
      if (valves_now() !== 5'b00000 || finished !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle cycle %0d got %b/%b want 00000/0", k, valves_now(), finished);
      end
    end
    pulse(1'b1, 1'b0);
    check_displays("reset_mid_coin");
  endtask

  task automatic test_random();
    int nc, t;
    bit c1, c5;
    for (int it = 0; it < 40; it++) begin
      nc = $urandom_range(0, 3);
      for (int j = 0; j < nc; j++) begin
        c1 = 1'($urandom_range(0, 1));
        c5 = 1'($urandom_range(0, 1));
        if (!c1 && !c5) c1 = 1'b1;
        pulse(c1, c5);
      end
      check_displays("rand_coins");
      t = $urandom_range(0, 7);
      if (price_of(t) != 0 && credit_m >= price_of(t))
        run_dispense(t, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 12) : 0, "rand_disp");
      else
        run_reject(t, "rand_reject");
    end
  endtask

  initial begin
`ifdef COFFEE_MACHINE_SUGAR_EN
    sugar_en = 1'b1;
`else
    sugar_en = 1'b0;
`endif
    test_reset();
    test_coins();
    test_mocha();
    test_insufficient();
    test_saturate();
    test_invalid();
    test_coin_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
